highlight_blend: RTL and testbench

- Parametrised successor to the motion highlighter; sits between the motion-mask FIFO, the original-frame FIFO and the output FIFO.
- Reads one mask word and one frame pixel together and writes one composited pixel.
- Adds a per-frame compositing mode (pass, replace, 50% blend, mask view) and one-pixel-per-cycle throughput.
- Optionally counts highlighted pixels per frame.

---
 rtl/highlight_blend.sv | 157 +++++++++++++++
 tb/tb_highlight_blend.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/highlight_blend.sv
// Motion highlighter: pops one mask word and one frame pixel together and writes one
// composited pixel per cycle. Define HIGHLIGHT_STATS_EN to count highlighted pixels per frame.
`timescale 1ns/1ps
module highlight_blend #(
  parameter int                        CH_W         = 8,
  parameter int                        NUM_CH       = 3,
  parameter int                        MASK_W       = 24,
  parameter logic [CH_W*NUM_CH-1:0]    HL_COLOR     = 'h0000ff,
  parameter int                        FRAME_PIXELS = 307200
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [1:0]                           mode,
  output logic                                 img_rd_en,
  input  logic                                 img_empty,
  input  logic [MASK_W-1:0]                    img_dout,
  output logic                                 fr_rd_en,
  input  logic                                 fr_empty,
  input  logic [CH_W*NUM_CH-1:0]               fr_dout,
  output logic                                 out_wr_en,
  input  logic                                 out_full,
  output logic [CH_W*NUM_CH-1:0]               out_din,
  output logic [$clog2(FRAME_PIXELS+1)-1:0]    hl_count,
  output logic                                 frame_done
);

  localparam int PIXEL_W = CH_W * NUM_CH;
  localparam int CNT_W   = $clog2(FRAME_PIXELS + 1);
  localparam int IDX_W   = $clog2(FRAME_PIXELS);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_REPLACE = 2'd1,
    MODE_BLEND   = 2'd2,
    MODE_MASK    = 2'd3
  } mode_e;

  // Per-channel average of two pixels; the extra sum bit keeps the carry before the shift.
  function automatic logic [PIXEL_W-1:0] blend_px(input logic [PIXEL_W-1:0] a,
                                                  input logic [PIXEL_W-1:0] b);
    logic [PIXEL_W-1:0] res;
    logic [CH_W:0]      sum;
    res = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum = {1'b0, a[ch*CH_W +: CH_W]} + {1'b0, b[ch*CH_W +: CH_W]};
      res[ch*CH_W +: CH_W] = sum[CH_W:1];
    end
    return res;
  endfunction

  logic [PIXEL_W-1:0] out_q, out_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   pixel_idx_q, pixel_idx_d;
  mode_e              mode_q, mode_d;
  logic               frame_done_q, frame_done_d;

  logic               accept;
  logic               m;
  logic               is_first, is_last;
  mode_e              mode_eff;
  logic [PIXEL_W-1:0] composite;

  assign m        = |img_dout;
  assign is_first = (pixel_idx_q == '0);
  assign is_last  = (pixel_idx_q == IDX_W'(FRAME_PIXELS - 1));
  // Gating with reset keeps both FIFOs untouched while the block is held in reset.
  assign accept   = reset && !img_empty && !fr_empty && (!valid_q || !out_full);

  assign img_rd_en  = accept;
  assign fr_rd_en   = accept;
  assign out_wr_en  = valid_q && !out_full;
  assign out_din    = out_q;
  assign frame_done = frame_done_q;

  // The first pixel of a frame uses the live mode input; the rest use the sampled copy.
  assign mode_eff = is_first ? mode_e'(mode) : mode_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    composite = fr_dout;
    case (mode_eff)
      MODE_PASS:    composite = fr_dout;
      MODE_REPLACE: if (m) composite = HL_COLOR;
      MODE_BLEND:   if (m) composite = blend_px(fr_dout, HL_COLOR);
      MODE_MASK:    composite = m ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
      default:      composite = fr_dout;
    endcase
  end

  always_comb begin
    out_d        = out_q;
    valid_d      = valid_q;
    pixel_idx_d  = pixel_idx_q;
    mode_d       = mode_q;
    frame_done_d = 1'b0;
    if (accept) begin
      out_d        = composite;
      valid_d      = 1'b1;
      pixel_idx_d  = is_last ? '0 : pixel_idx_q + 1'b1;
      frame_done_d = is_last;
      if (is_first) mode_d = mode_e'(mode);
    end else if (out_wr_en) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q        <= '0;
      valid_q      <= 1'b0;
      pixel_idx_q  <= '0;
      mode_q       <= MODE_PASS;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      out_q        <= out_d;
      valid_q      <= valid_d;
      pixel_idx_q  <= pixel_idx_d;
      mode_q       <= mode_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef HIGHLIGHT_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hl_count_q, hl_count_d;

  always_comb begin
    cnt_d      = cnt_q;
    hl_count_d = hl_count_q;
    if (accept) begin
      if (is_last) begin
        // The last pixel's own mask bit is folded in as the frame closes.
        hl_count_d = cnt_q + CNT_W'(m);
        cnt_d      = '0;
      end else if (m && (cnt_q != CNT_W'(FRAME_PIXELS))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      hl_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      hl_count_q <= hl_count_d;
    end
  end

  assign hl_count = hl_count_q;
`else
  assign hl_count = '0;
`endif

endmodule

// File: tb/tb_highlight_blend.sv
// Directed bench for highlight_blend with a 4-pixel frame: FIFO models on both inputs,
// an ordered expected-output queue and per-frame highlight counts.
`timescale 1ns/1ps
module tb_highlight_blend;

  localparam int FP    = 4;
  localparam int CNT_W = $clog2(FP + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic             img_rd_en;
  logic             img_empty = 1'b1;
  logic [23:0]      img_dout = '0;
  logic             fr_rd_en;
  logic             fr_empty = 1'b1;
  logic [23:0]      fr_dout = '0;
  logic             out_wr_en;
  logic             out_full = 1'b0;
  logic [23:0]      out_din;
  logic [CNT_W-1:0] hl_count;
  logic             frame_done;

  always #5 clock = ~clock;

  highlight_blend #(
    .CH_W(8), .NUM_CH(3), .MASK_W(24), .HL_COLOR(24'h0000ff), .FRAME_PIXELS(FP)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .img_rd_en(img_rd_en), .img_empty(img_empty), .img_dout(img_dout),
    .fr_rd_en(fr_rd_en), .fr_empty(fr_empty), .fr_dout(fr_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .hl_count(hl_count), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  logic [23:0] mask_s[$];
  logic [23:0] pix_s[$];
  logic [1:0]  mode_s[$];
  logic [23:0] exp_s[$];
  int          hl_s[$];

  bit          force_fr_empty = 0;
  bit          force_full     = 0;
  bit          exp_valid      = 0;
  bit          fd_exp         = 0;
  bit          prev_full      = 0;
  logic [23:0] prev_out       = '0;
  int          popcnt         = 0;

  function automatic int hl_exp(input int n);
`ifdef HIGHLIGHT_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic push(input logic [1:0] md, input logic [23:0] mk,
                      input logic [23:0] pix, input logic [23:0] exp);
    mode_s.push_back(md);
    mask_s.push_back(mk);
    pix_s.push_back(pix);
    exp_s.push_back(exp);
  endtask

  task automatic apply_inputs();
    img_empty = (mask_s.size() == 0);
    img_dout  = (mask_s.size() != 0) ? mask_s[0] : 24'h0;
    fr_empty  = (pix_s.size() == 0) || force_fr_empty;
    fr_dout   = (pix_s.size() != 0) ? pix_s[0] : 24'h0;
    mode      = (mode_s.size() != 0) ? mode_s[0] : 2'd0;
    out_full  = force_full;
  endtask

  // One clock: drive, sample at the falling edge, then advance the FIFO/output model.
  task automatic step();
    bit acc;
    bit wr;
    apply_inputs();
    @(negedge clock);
    acc = reset && !img_empty && !fr_empty && (!exp_valid || !out_full);
    wr  = exp_valid && !out_full;
    check("img_rd_en", img_rd_en, acc);
    check("fr_rd_en", fr_rd_en, acc);
    check("out_wr_en", out_wr_en, wr);
    check("frame_done", frame_done, fd_exp);
    if (fd_exp && hl_s.size() > 0) check("hl_count", hl_count, hl_s.pop_front());
    if (wr) begin
      check("output_expected", exp_s.size() > 0, 1);
      if (exp_s.size() > 0) check("out_din", out_din, exp_s.pop_front());
    end
    if (out_full && prev_full && exp_valid) check("out_din_hold", out_din, prev_out);
    prev_out  = out_din;
    prev_full = out_full;
    @(posedge clock);
    #1;
    fd_exp = acc && (popcnt % FP == FP - 1);
    if (acc) begin
      void'(mask_s.pop_front());
      void'(pix_s.pop_front());
      void'(mode_s.pop_front());
      popcnt++;
      exp_valid = 1;
    end else if (wr) begin
      exp_valid = 0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_s.size() > 0 || exp_valid || mask_s.size() > 0) && k < 200) begin
      step();
      k++;
    end
    check("drain_in_budget", k < 200, 1);
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_out_din", out_din, 24'h0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_hl_count", hl_count, 0);
    img_empty = 1'b0;
    fr_empty  = 1'b0;
    #1;
    check("rst_img_rd_en", img_rd_en, 0);
    check("rst_fr_rd_en", fr_rd_en, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Frame A: replace mode; the mode change on pixel 2 must be ignored.
    push(2'd1, 24'h000000, 24'h123456, 24'h123456);
    push(2'd1, 24'h000001, 24'habcdef, 24'h0000ff);
    push(2'd3, 24'h000001, 24'h111111, 24'h0000ff);
    push(2'd3, 24'h000001, 24'h222222, 24'h0000ff);
    hl_s.push_back(hl_exp(3));
    // Frame B: mask view.
    push(2'd3, 24'h000001, 24'h333333, 24'hffffff);
    push(2'd3, 24'h000000, 24'h444444, 24'h000000);
    push(2'd2, 24'h800000, 24'h555555, 24'hffffff);
    push(2'd2, 24'h000000, 24'h666666, 24'h000000);
    hl_s.push_back(hl_exp(2));
    // Frame C: 50% blend, including the carry-out channel cases.
    push(2'd2, 24'h000010, 24'h80ff01, 24'h407f80);
    push(2'd2, 24'h000000, 24'habcdef, 24'habcdef);
    push(2'd2, 24'h000001, 24'hffffff, 24'h7f7fff);
    push(2'd0, 24'h000001, 24'h010101, 24'h000080);
    hl_s.push_back(hl_exp(3));
    // Frame D: pass, with mode switched to replace during pixel 2.
    push(2'd0, 24'h000001, 24'ha1a2a3, 24'ha1a2a3);
    push(2'd0, 24'h000000, 24'hb1b2b3, 24'hb1b2b3);
    push(2'd1, 24'h000001, 24'hc1c2c3, 24'hc1c2c3);
    push(2'd1, 24'h000001, 24'hd1d2d3, 24'hd1d2d3);
    hl_s.push_back(hl_exp(3));
    // Frame E: replace takes effect from the first pixel of the new frame.
    push(2'd1, 24'h000001, 24'he0e0e0, 24'h0000ff);
    push(2'd1, 24'h000000, 24'hf0f0f0, 24'hf0f0f0);
    push(2'd1, 24'h000001, 24'h0a0b0c, 24'h0000ff);
    push(2'd1, 24'h000000, 24'h102030, 24'h102030);
    hl_s.push_back(hl_exp(2));
    drain();

    // Ten-pixel stream with the output full for five cycles from cycle 3.
    for (int i = 0; i < 10; i++)
      push(2'd0, (i % 2 == 0) ? 24'h000001 : 24'h000000, 24'h100000 + 24'(i), 24'h100000 + 24'(i));
    hl_s.push_back(hl_exp(2));
    hl_s.push_back(hl_exp(2));
    for (int c = 0; c < 30; c++) begin
      force_full = (c >= 3 && c < 8);
      step();
    end
    force_full = 0;
    drain();

    // Frame FIFO empty on its own: the mask FIFO must not be popped.
    push(2'd0, 24'h000000, 24'h0a0a0a, 24'h0a0a0a);
    force_fr_empty = 1;
    repeat (4) step();
    force_fr_empty = 0;
    push(2'd0, 24'h000001, 24'h0b0b0b, 24'h0b0b0b);
    hl_s.push_back(hl_exp(2));
    drain();

    // Reset two pixels into a frame: in-flight pixel dropped, next pixel starts a frame.
    push(2'd0, 24'h000001, 24'h5a5a5a, 24'h5a5a5a);
    push(2'd0, 24'h000001, 24'h6b6b6b, 24'h6b6b6b);
    step();
    step();
    reset = 1'b0;
    #1;
    check("midrst_out_din", out_din, 24'h0);
    check("midrst_out_wr_en", out_wr_en, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_hl_count", hl_count, 0);
    exp_s.delete();
    exp_valid = 0;
    fd_exp    = 0;
    popcnt    = 0;
    push(2'd3, 24'h000001, 24'h123123, 24'hffffff);
    push(2'd3, 24'h000000, 24'h234234, 24'h000000);
    push(2'd0, 24'h000001, 24'h345345, 24'hffffff);
    push(2'd0, 24'h000000, 24'h456456, 24'h000000);
    hl_s.push_back(hl_exp(2));
    apply_inputs();
    #1;
    check("midrst_img_rd_en", img_rd_en, 0);
    check("midrst_fr_rd_en", fr_rd_en, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    drain();

    check("all_expected_consumed", exp_s.size() + hl_s.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
